mio_bus_responder: RTL and testbench

//  Slave side of the CPU memory/IO (MIO) bus; services word requests from the single-cycle CPU core.

---
 rtl/mio_pkg.sv | 29 ++
 rtl/mio_addr_decode.sv | 30 +++
 rtl/mio_bus_responder.sv | 155 +++++++++++++++
 tb/tb_mio_bus_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus responder: region addresses, FSM states
// and the region select codes produced by the address decoder.
package mio_pkg;

    localparam logic [31:0] LED_ADDR = 32'hE000_0000;
    localparam logic [31:0] SW_ADDR  = 32'hF000_0000;
    localparam logic [31:0] CNT_ADDR = 32'hF000_0004;
    localparam logic [3:0]  RAM_TOP  = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        RG_NONE = 3'd0,
        RG_RAM  = 3'd1,
        RG_LED  = 3'd2,
        RG_SW   = 3'd3,
        RG_CNT  = 3'd4
    } region_e;

    // Byte-lane bits never take part in decoding.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational decode of a CPU byte address into a target region and the
// RAM word index (upper RAM-window bits alias).
module mio_addr_decode
    import mio_pkg::*;
#(
    parameter int RAM_AW = 10
) (
    input  logic [31:0]       addr,
    output region_e           region,
    output logic [RAM_AW-1:0] ram_index
);

    logic [31:0] aligned;

    always_comb begin
        aligned   = word_align(addr);
        ram_index = addr[RAM_AW+1:2];
        region    = RG_NONE;
        if (addr[31:28] == RAM_TOP) begin
            region = RG_RAM;
        end else if (aligned == LED_ADDR) begin
            region = RG_LED;
        end else if (aligned == SW_ADDR) begin
            region = RG_SW;
        end else if (aligned == CNT_ADDR) begin
            region = RG_CNT;
        end
    end

endmodule

// File: rtl/mio_bus_responder.sv
// Slave side of the CPU MIO bus: one request at a time through IDLE -> ACCESS
// -> RESP, targeting synchronous RAM, the LED register, switches or the counter.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int RAM_AW  = 10,
    parameter int RAM_LAT = 1,
    parameter int LED_W   = 16,
    parameter int SW_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CPU_MIO,
    input  logic              MemRW,
    input  logic [31:0]       Addr_in,
    input  logic [31:0]       Data_w,
    output logic [31:0]       Data_r,
    output logic              MIO_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    output logic [LED_W-1:0]  led,
    input  logic [SW_W-1:0]   sw,
    output logic [1:0]        state_dbg
);

    localparam logic [7:0] WAIT_LAST = 8'(RAM_LAT - 1);

    state_e            state;
    state_e            state_next;
    region_e           dec_region;
    logic [RAM_AW-1:0] dec_index;

    region_e           region_q;
    logic [RAM_AW-1:0] index_q;
    logic [31:0]       data_q;
    logic              write_q;
    logic [7:0]        wait_cnt;

    logic [31:0]       cnt;
    logic [SW_W-1:0]   sw_meta;
    logic [SW_W-1:0]   sw_sync;

    logic              accept;
    logic              access_done;
    logic [31:0]       read_val;

    mio_addr_decode #(
        .RAM_AW (RAM_AW)
    ) u_decode (
        .addr      (Addr_in),
        .region    (dec_region),
        .ram_index (dec_index)
    );

    assign state_dbg = state;

    // The RAM sees the live CPU address in IDLE so a latency-1 RAM has data
    // ready by the end of the first ACCESS cycle.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        access_done = 1'b0;
        ram_we      = 1'b0;
        MIO_ready   = 1'b0;
        ram_wdata   = data_q;
        ram_addr    = (state == ST_IDLE) ? dec_index : index_q;
        case (state)
            ST_IDLE: begin
                if (CPU_MIO) begin
                    accept     = 1'b1;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (region_q == RG_RAM) begin
                    if (write_q) begin
                        ram_we      = 1'b1;
                        access_done = 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        access_done = 1'b1;
                    end
                end else begin
                    access_done = 1'b1;
                end
                if (access_done) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                MIO_ready  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Counter reads return the value held during ACCESS, before this edge's increment.
    always_comb begin
        read_val = 32'h0;
        case (region_q)
            RG_RAM:  read_val = ram_rdata;
            RG_LED:  read_val = 32'(led);
            RG_SW:   read_val = 32'(sw_sync);
            RG_CNT:  read_val = cnt;
            default: read_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            region_q <= RG_NONE;
            index_q  <= '0;
            data_q   <= '0;
            write_q  <= 1'b0;
            wait_cnt <= '0;
            Data_r   <= '0;
            led      <= '0;
            cnt      <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            state   <= state_next;
            sw_meta <= sw;
            sw_sync <= sw_meta;

            if (accept) begin
                region_q <= dec_region;
                index_q  <= dec_index;
                data_q   <= Data_w;
                write_q  <= MemRW;
                wait_cnt <= '0;
            end else if (state == ST_ACCESS) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (access_done && !write_q) begin
                Data_r <= read_val;
            end

            if (access_done && write_q && region_q == RG_LED) begin
                led <= data_q[LED_W-1:0];
            end

            if (access_done && write_q && region_q == RG_CNT) begin
                cnt <= data_q;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder with a latency-2 synchronous RAM model.
module tb_mio_bus_responder;

    localparam int RAM_AW  = 10;
    localparam int RAM_LAT = 2;
    localparam int LED_W   = 16;
    localparam int SW_W    = 16;

    logic              clk;
    logic              rst;
    logic              CPU_MIO;
    logic              MemRW;
    logic [31:0]       Addr_in;
    logic [31:0]       Data_w;
    logic [31:0]       Data_r;
    logic              MIO_ready;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic [31:0]       ram_rdata;
    logic [LED_W-1:0]  led;
    logic [SW_W-1:0]   sw;
    logic [1:0]        state_dbg;

    int n_vec;
    int n_err;
    int ready_cnt;
    int we_cnt;
    logic [31:0] exp_q[$];

    logic [31:0] mem [0:(1<<RAM_AW)-1];
    logic [31:0] rd_p0;
    logic [31:0] rd_p1;

    mio_bus_responder #(
        .RAM_AW  (RAM_AW),
        .RAM_LAT (RAM_LAT),
        .LED_W   (LED_W),
        .SW_W    (SW_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .CPU_MIO   (CPU_MIO),
        .MemRW     (MemRW),
        .Addr_in   (Addr_in),
        .Data_w    (Data_w),
        .Data_r    (Data_r),
        .MIO_ready (MIO_ready),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .led       (led),
        .sw        (sw),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage read pipe: address sampled at an edge, data visible two cycles on.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        rd_p0 <= mem[ram_addr];
        rd_p1 <= rd_p0;
    end
    assign ram_rdata = rd_p1;

    always @(negedge clk) begin
        if (MIO_ready === 1'b1) ready_cnt++;
        if (ram_we === 1'b1) we_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Driver: request from a negedge, hold until MIO_ready, then finish RESP.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat);
        @(negedge clk);
        CPU_MIO = 1'b1;
        MemRW   = w;
        Addr_in = a;
        Data_w  = d;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (MIO_ready) break;
        end
        CPU_MIO = 1'b0;
        MemRW   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        int lat;
        int r0;
        r0 = ready_cnt;
        do_req(1'b1, a, d, lat);
        check({tag, "_lat"}, lat, 2);
        check({tag, "_rdy"}, ready_cnt - r0, 1);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp,
                           input int exp_lat);
        int lat;
        exp_q.push_back(exp);
        do_req(1'b0, a, 32'h0, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, Data_r, exp_q.pop_front());
    endtask

    initial begin
        int w0;
        int r0;
        n_vec = 0;
        n_err = 0;
        ready_cnt = 0;
        we_cnt = 0;
        for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = 32'h0;
        rd_p0 = 32'h0;
        rd_p1 = 32'h0;
        rst = 1'b0;
        CPU_MIO = 1'b0;
        MemRW = 1'b0;
        Addr_in = 32'h0;
        Data_w = 32'h0;
        sw = '0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(MIO_ready), 0);
        check("rst_data", Data_r, 0);
        check("rst_we", 32'(ram_we), 0);
        check("rst_led", 32'(led), 0);
        check("rst_state", 32'(state_dbg), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // RAM write then read, including an aliased address
        w0 = we_cnt;
        do_write("ram_wr", 32'h0000_0040, 32'hDEAD_BEEF);
        check("ram_we_pulses", we_cnt - w0, 1);
        check("ram_mem16", mem[16], 32'hDEAD_BEEF);
        do_write("ram_wr44", 32'h0000_0044, 32'h1122_3344);
        w0 = we_cnt;
        do_read("ram_rd40", 32'h0000_0040, 32'hDEAD_BEEF, 3);
        do_read("ram_rd44", 32'h0000_0044, 32'h1122_3344, 3);
        do_read("ram_alias", 32'h0000_1040, 32'hDEAD_BEEF, 3);
        check("ram_rd_no_we", we_cnt - w0, 0);

        // LED and switches
        do_write("led_wr", 32'hE000_0000, 32'hFFFF_A5A5);
        check("led_val", 32'(led), 32'h0000_A5A5);
        do_read("led_rd", 32'hE000_0002, 32'h0000_A5A5, 2);
        sw = 16'h00FF;
        repeat (3) @(posedge clk);
        #1;
        do_read("sw_rd", 32'hF000_0000, 32'h0000_00FF, 2);

        // Counter: load wins over increment, then wraps through zero
        do_write("cnt_wr", 32'hF000_0004, 32'hFFFF_FFFE);
        do_read("cnt_wrap", 32'hF000_0004, 32'h0000_0000, 2);
        do_write("cnt_wr2", 32'hF000_0004, 32'h0000_0100);
        do_read("cnt_rd2", 32'hF000_0004, 32'h0000_0102, 2);

        // Unmapped accesses
        do_read("unm_rd", 32'h8000_0000, 32'h0000_0000, 2);
        do_write("cnt_wr3", 32'hF000_0004, 32'h0000_0200);
        w0 = we_cnt;
        do_write("unm_wr", 32'h8000_0000, 32'h5555_AAAA);
        do_write("unm_wr2", 32'hE000_0008, 32'h0000_1111);
        check("unm_no_we", we_cnt - w0, 0);
        check("unm_led", 32'(led), 32'h0000_A5A5);
        check("unm_mem0", mem[0], 32'h0);
        do_read("unm_cnt", 32'hF000_0004, 32'h0000_0208, 2);

        // Request held through RESP: one pulse only
        r0 = ready_cnt;
        @(negedge clk);
        CPU_MIO = 1'b1;
        MemRW   = 1'b0;
        Addr_in = 32'hE000_0000;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (MIO_ready) break;
        end
        @(posedge clk);
        #1;
        CPU_MIO = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("hold_pulses", ready_cnt - r0, 1);
        check("hold_idle", 32'(state_dbg), 0);

        // Request dropped during ACCESS still completes
        r0 = ready_cnt;
        @(negedge clk);
        CPU_MIO = 1'b1;
        MemRW   = 1'b1;
        Addr_in = 32'hE000_0000;
        Data_w  = 32'h0000_0F0F;
        @(posedge clk);
        #1;
        CPU_MIO = 1'b0;
        MemRW   = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("drop_pulses", ready_cnt - r0, 1);
        check("drop_led", 32'(led), 32'h0000_0F0F);

        // Reset in the middle of an LED write
        @(negedge clk);
        CPU_MIO = 1'b1;
        MemRW   = 1'b1;
        Addr_in = 32'hE000_0000;
        Data_w  = 32'h0000_1234;
        @(posedge clk);
        #1;
        check("mid_access", 32'(state_dbg), 1);
        r0 = ready_cnt;
        rst = 1'b0;
        #1;
        check("mid_rst_led", 32'(led), 0);
        check("mid_rst_state", 32'(state_dbg), 0);
        check("mid_rst_data", Data_r, 0);
        CPU_MIO = 1'b0;
        MemRW   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_noready", ready_cnt - r0, 0);
        check("mid_rst_led2", 32'(led), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
